// File: rtl/icache_sa.sv
// icache_sa: parametrised set-associative instruction cache.
// A small FSM (IDLE/LOOKUP/MISS_REQ/REFILL/RESP) serves one fetch at a time;
// misses refill a whole line in MEM_W-wide beats into a victim way chosen
// lowest-invalid-first, else by a per-set round-robin pointer.
// Optional macro ICACHE_PERF_EN adds 64-bit hit/miss counters.
module icache_sa #(
  parameter int ADDR_W     = 64,
  parameter int NUM_SETS   = 256,
  parameter int NUM_WAYS   = 2,
  parameter int LINE_BYTES = 16,
  parameter int MEM_W      = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_pc,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_instr,
  output logic [ADDR_W-1:0] resp_pc,
  output logic              resp_fault,
  input  logic              flush,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_resp_valid,
  input  logic [MEM_W-1:0]  mem_resp_data
`ifdef ICACHE_PERF_EN
  ,
  output logic [63:0]       perf_hit_cnt,
  output logic [63:0]       perf_miss_cnt
`endif
);

  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int IDX_W  = $clog2(NUM_SETS);
  localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;
  localparam int LINE_W = LINE_BYTES * 8;
  localparam int WORD_W = OFF_W - 2;
  localparam int BEATS  = LINE_W / MEM_W;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int WAY_W  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_MISS_REQ,
    S_REFILL,
    S_RESP
  } state_t;

  state_t              r_state;
  logic                r_req_ready;
  logic                r_resp_valid;
  logic                r_resp_fault;
  logic                r_mem_req_valid;
  logic [31:0]         r_resp_instr;
  logic [ADDR_W-1:0]   r_resp_pc;
  logic [ADDR_W-1:0]   r_pc;
  logic [BEAT_W-1:0]   r_beat;
  logic [LINE_W-1:0]   r_line;

  logic [NUM_WAYS-1:0] r_valid [NUM_SETS];
  logic [WAY_W-1:0]    r_rr    [NUM_SETS];
  logic [TAG_W-1:0]    r_tag   [NUM_SETS][NUM_WAYS];
  logic [LINE_W-1:0]   r_data  [NUM_SETS][NUM_WAYS];

  logic [IDX_W-1:0]    w_idx;
  logic [TAG_W-1:0]    w_tag;
  logic [WORD_W-1:0]   w_word;
  logic                w_misalign;
  logic                w_hit;
  logic [LINE_W-1:0]   w_hit_line;
  logic [WAY_W-1:0]    w_victim;
  logic                w_found_inv;
  logic [LINE_W-1:0]   w_fill_line;
  logic                w_last_beat;
  logic                w_fill_we;
  logic [WAY_W-1:0]    w_rr_next;

  // Pick one 32-bit instruction word out of a line (word 0 at lowest address).
  function automatic logic [31:0] word_of(input logic [LINE_W-1:0] line,
                                          input logic [WORD_W-1:0] sel);
    word_of = line[int'(sel)*32 +: 32];
  endfunction

  assign w_idx       = r_pc[OFF_W +: IDX_W];
  assign w_tag       = r_pc[ADDR_W-1 -: TAG_W];
  assign w_word      = r_pc[OFF_W-1:2];
  assign w_misalign  = (r_pc[1:0] != 2'b00);
  assign w_last_beat = (r_beat == BEAT_W'(BEATS-1));
  assign w_fill_we   = (r_state == S_REFILL) && mem_resp_valid && w_last_beat;
  assign w_rr_next   = (r_rr[w_idx] == WAY_W'(NUM_WAYS-1)) ? '0 : r_rr[w_idx] + 1'b1;

  assign req_ready     = r_req_ready;
  assign resp_valid    = r_resp_valid;
  assign resp_instr    = r_resp_instr;
  assign resp_pc       = r_resp_pc;
  assign resp_fault    = r_resp_fault;
  assign mem_req_valid = r_mem_req_valid;
  assign mem_req_addr  = {r_pc[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

  // Tag compare across all ways of the indexed set.
  always_comb begin
    w_hit      = 1'b0;
    w_hit_line = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
        w_hit      = 1'b1;
        w_hit_line = r_data[w_idx][w];
      end
    end
  end

  // Victim: lowest-index invalid way, otherwise the set's round-robin pointer.
  always_comb begin
    w_victim    = r_rr[w_idx];
    w_found_inv = 1'b0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!w_found_inv && !r_valid[w_idx][w]) begin
        w_victim    = WAY_W'(w);
        w_found_inv = 1'b1;
      end
    end
  end

  // Refill line as it will look once the current beat is merged in.
  always_comb begin
    w_fill_line = r_line;
    w_fill_line[int'(r_beat)*MEM_W +: MEM_W] = mem_resp_data;
  end

  // Control FSM with registered handshake and response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_req_ready     <= 1'b0;
      r_resp_valid    <= 1'b0;
      r_resp_fault    <= 1'b0;
      r_resp_instr    <= '0;
      r_resp_pc       <= '0;
      r_mem_req_valid <= 1'b0;
      r_beat          <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_req_ready <= 1'b1;
          if (req_valid && r_req_ready) begin
            r_req_ready <= 1'b0;
            r_state     <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (w_misalign) begin
            r_resp_valid <= 1'b1;
            r_resp_fault <= 1'b1;
            r_resp_instr <= '0;
            r_resp_pc    <= r_pc;
            r_state      <= S_RESP;
          end else if (w_hit) begin
            r_resp_valid <= 1'b1;
            r_resp_fault <= 1'b0;
            r_resp_instr <= word_of(w_hit_line, w_word);
            r_resp_pc    <= r_pc;
            r_state      <= S_RESP;
          end else begin
            r_mem_req_valid <= 1'b1;
            r_state         <= S_MISS_REQ;
          end
        end
        S_MISS_REQ: begin
          if (mem_req_ready) begin
            r_mem_req_valid <= 1'b0;
            r_beat          <= '0;
            r_state         <= S_REFILL;
          end
        end
        S_REFILL: begin
          if (mem_resp_valid) begin
            if (w_last_beat) begin
              r_beat       <= '0;
              r_resp_valid <= 1'b1;
              r_resp_fault <= 1'b0;
              r_resp_instr <= word_of(w_fill_line, w_word);
              r_resp_pc    <= r_pc;
              r_state      <= S_RESP;
            end else begin
              r_beat <= r_beat + 1'b1;
            end
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Datapath capture: accepted PC and refill beat assembly.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && req_valid && r_req_ready)
      r_pc <= req_pc;
    if (r_state == S_REFILL && mem_resp_valid)
      r_line <= w_fill_line;
  end

  // Valid bits and replacement pointers; flush wins over a same-edge fill.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        r_valid[s] <= '0;
        r_rr[s]    <= '0;
      end
    end else begin
      if (w_fill_we)
        r_rr[w_idx] <= w_rr_next;
      if (flush) begin
        for (int s = 0; s < NUM_SETS; s++)
          r_valid[s] <= '0;
      end else if (w_fill_we) begin
        r_valid[w_idx][w_victim] <= 1'b1;
      end
    end
  end

  // Tag and data array write on the final refill beat.
  always_ff @(posedge clk) begin
    if (w_fill_we && !rst) begin
      r_tag[w_idx][w_victim]  <= w_tag;
      r_data[w_idx][w_victim] <= w_fill_line;
    end
  end

`ifdef ICACHE_PERF_EN
  logic [63:0] r_hit_cnt;
  logic [63:0] r_miss_cnt;

  assign perf_hit_cnt  = r_hit_cnt;
  assign perf_miss_cnt = r_miss_cnt;

  // One count per aligned lookup; faults are not counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (r_state == S_LOOKUP && !w_misalign) begin
      if (w_hit)
        r_hit_cnt <= r_hit_cnt + 64'd1;
      else
        r_miss_cnt <= r_miss_cnt + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_sa.sv
// tb_icache_sa: directed bench for icache_sa with default parameters.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_icache_sa;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_pc;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_instr;
  logic [63:0] resp_pc;
  logic        resp_fault;
  logic        flush;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_data;
`ifdef ICACHE_PERF_EN
  logic [63:0] perf_hit_cnt;
  logic [63:0] perf_miss_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  icache_sa dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_pc         (req_pc),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_instr     (resp_instr),
    .resp_pc        (resp_pc),
    .resp_fault     (resp_fault),
    .flush          (flush),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data)
`ifdef ICACHE_PERF_EN
    ,
    .perf_hit_cnt   (perf_hit_cnt),
    .perf_miss_cnt  (perf_miss_cnt)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".req_ready"},     {63'd0, req_ready},     64'd0);
    check({tag, ".resp_valid"},    {63'd0, resp_valid},    64'd0);
    check({tag, ".resp_fault"},    {63'd0, resp_fault},    64'd0);
    check({tag, ".mem_req_valid"}, {63'd0, mem_req_valid}, 64'd0);
    check({tag, ".resp_instr"},    {32'd0, resp_instr},    64'd0);
    check({tag, ".resp_pc"},       resp_pc,                64'd0);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs(tag);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // One fetch: serves a 2-beat refill if the cache asks for one.
  task automatic fetch(input string tag, input logic [63:0] pc, input logic exp_miss,
                       input logic [63:0] b0, input logic [63:0] b1,
                       input logic [31:0] exp_instr, input logic exp_fault,
                       input logic flush_last);
    int   n;
    int   lat;
    logic seen;
    logic got;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, ".req_ready"}, {63'd0, req_ready}, 64'd1);
    req_valid = 1'b1;
    req_pc    = pc;
    @(negedge clk);
    req_valid = 1'b0;
    lat  = 1;
    seen = 1'b0;
    got  = 1'b0;
    while (lat < 60) begin
      if (resp_valid) begin
        got = 1'b1;
        break;
      end
      if (mem_req_valid && mem_req_ready) begin
        seen = 1'b1;
        check({tag, ".mem_addr"}, mem_req_addr, {pc[63:4], 4'h0});
        @(negedge clk);
        mem_resp_valid = 1'b1;
        mem_resp_data  = b0;
        @(negedge clk);
        mem_resp_data  = b1;
        flush          = flush_last;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        flush          = 1'b0;
        lat += 3;
        continue;
      end
      @(negedge clk);
      lat++;
    end
    check({tag, ".resp_seen"},  {63'd0, got},        64'd1);
    check({tag, ".mem_req"},    {63'd0, seen},       {63'd0, exp_miss});
    check({tag, ".instr"},      {32'd0, resp_instr}, {32'd0, exp_instr});
    check({tag, ".pc"},         resp_pc,             pc);
    check({tag, ".fault"},      {63'd0, resp_fault}, {63'd0, exp_fault});
    if (!exp_miss)
      check({tag, ".latency"}, 64'(lat), 64'd2);
    @(negedge clk);
  endtask

  initial begin
    rst            = 1'b1;
    req_valid      = 1'b0;
    req_pc         = '0;
    resp_ready     = 1'b1;
    flush          = 1'b0;
    mem_req_ready  = 1'b1;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;

    // Cold miss then hit in the same line.
    do_reset("rst0");
    fetch("t1_miss", 64'h8000_0004, 1'b1, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888,
          32'h1111_2222, 1'b0, 1'b0);
    fetch("t1_hit", 64'h8000_000C, 1'b0, 64'h0, 64'h0, 32'h5555_6666, 1'b0, 1'b0);

    // Eviction in set 0: after two refills the pointer is back at way 0.
    do_reset("rst1");
    fetch("t2_a", 64'h8000_0000, 1'b1, 64'hAAAA_0001_AAAA_0000, 64'hAAAA_0003_AAAA_0002,
          32'hAAAA_0000, 1'b0, 1'b0);
    fetch("t2_b", 64'h8000_1000, 1'b1, 64'hBBBB_0001_BBBB_0000, 64'hBBBB_0003_BBBB_0002,
          32'hBBBB_0000, 1'b0, 1'b0);
    fetch("t2_c", 64'h8000_2000, 1'b1, 64'hCCCC_0001_CCCC_0000, 64'hCCCC_0003_CCCC_0002,
          32'hCCCC_0000, 1'b0, 1'b0);
    fetch("t2_b_hit", 64'h8000_1004, 1'b0, 64'h0, 64'h0, 32'hBBBB_0001, 1'b0, 1'b0);
    fetch("t2_a_miss", 64'h8000_0000, 1'b1, 64'hAAAA_0001_AAAA_0000, 64'hAAAA_0003_AAAA_0002,
          32'hAAAA_0000, 1'b0, 1'b0);
    fetch("t2_c_hit", 64'h8000_2008, 1'b0, 64'h0, 64'h0, 32'hCCCC_0002, 1'b0, 1'b0);

    // Backpressure on both the refill request and the response.
    do_reset("rst2");
    mem_req_ready = 1'b0;
    resp_ready    = 1'b0;
    req_valid = 1'b1;
    req_pc    = 64'h8000_0048;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("t3_mreq_valid", {63'd0, mem_req_valid}, 64'd1);
      check("t3_mreq_addr",  mem_req_addr,           64'h8000_0040);
      @(negedge clk);
    end
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_resp_valid = 1'b1;
    mem_resp_data  = 64'h0123_4567_89AB_CDEF;
    @(negedge clk);
    mem_resp_data  = 64'hFEDC_BA98_7654_3210;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("t3_resp_valid", {63'd0, resp_valid}, 64'd1);
      check("t3_resp_instr", {32'd0, resp_instr}, 64'h7654_3210);
      check("t3_resp_pc",    resp_pc,             64'h8000_0048);
      check("t3_req_ready",  {63'd0, req_ready},  64'd0);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    check("t3_resp_done", {63'd0, resp_valid}, 64'd0);
    check("t3_idle_ready", {63'd0, req_ready}, 64'd1);

    // Flush in IDLE, then flush coinciding with the final refill beat.
    do_reset("rst3");
    fetch("t4_fill", 64'h8000_0004, 1'b1, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888,
          32'h1111_2222, 1'b0, 1'b0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    fetch("t4_refetch", 64'h8000_0004, 1'b1, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888,
          32'h1111_2222, 1'b0, 1'b0);
    fetch("t4_flush_beat", 64'h8000_0100, 1'b1, 64'hDDDD_0001_DDDD_0000, 64'hDDDD_0003_DDDD_0002,
          32'hDDDD_0000, 1'b0, 1'b1);
    fetch("t4_after", 64'h8000_0104, 1'b1, 64'hDDDD_0001_DDDD_0000, 64'hDDDD_0003_DDDD_0002,
          32'hDDDD_0001, 1'b0, 1'b0);

    // Misaligned PCs, cold and on a cached line.
    fetch("t5_mis", 64'h8000_0002, 1'b0, 64'h0, 64'h0, 32'h0, 1'b1, 1'b0);
    fetch("t5_mis_cached", 64'h8000_0106, 1'b0, 64'h0, 64'h0, 32'h0, 1'b1, 1'b0);

    // Reset after the first refill beat aborts the refill.
    req_valid = 1'b1;
    req_pc    = 64'h8000_0200;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("t6_mreq", {63'd0, mem_req_valid}, 64'd1);
    @(negedge clk);
    mem_resp_valid = 1'b1;
    mem_resp_data  = 64'hEEEE_0001_EEEE_0000;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("t6_rst");
    rst = 1'b0;
    @(negedge clk);
    fetch("t6_fresh", 64'h8000_0200, 1'b1, 64'h9999_0001_9999_0000, 64'h9999_0003_9999_0002,
          32'h9999_0000, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
